// File: rtl/gemm_tile_sequencer_if.sv
// Host/controller-facing signal bundle for gemm_tile_sequencer.
// The host side drives start/abort/config/valid; the sequencer drives control and addresses.
interface gemm_tile_sequencer_if #(
  parameter int unsigned NUM_COL              = 8,
  parameter int unsigned LOG2_SRAM_BANK_DEPTH = 10,
  parameter int unsigned CNT_WIDTH            = 16,
  parameter int unsigned CTRL_WIDTH           = 4
) ();

  logic                            i_start;
  logic                            i_abort;
  logic [CNT_WIDTH-1:0]            i_cfg_k;
  logic [CNT_WIDTH-1:0]            i_cfg_num_m_tiles;
  logic [CNT_WIDTH-1:0]            i_cfg_num_n_tiles;
  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_cfg_top_base;
  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_cfg_left_base;
  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_cfg_down_base;
  logic [NUM_COL-1:0]              i_sa_valid_down;

  logic [CTRL_WIDTH-1:0]           o_ctrl_state;
  logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_sram_rd_start_addr;
  logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_sram_rd_end_addr;
  logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_sram_rd_start_addr;
  logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_sram_rd_end_addr;
  logic [LOG2_SRAM_BANK_DEPTH-1:0] o_down_tile_base_addr;
  logic [CNT_WIDTH-1:0]            o_tile_m_idx;
  logic [CNT_WIDTH-1:0]            o_tile_n_idx;
  logic                            o_busy;
  logic                            o_done;
  logic                            o_err;

  modport master (
    output i_start, i_abort, i_cfg_k, i_cfg_num_m_tiles, i_cfg_num_n_tiles,
    output i_cfg_top_base, i_cfg_left_base, i_cfg_down_base, i_sa_valid_down,
    input  o_ctrl_state, o_top_sram_rd_start_addr, o_top_sram_rd_end_addr,
    input  o_left_sram_rd_start_addr, o_left_sram_rd_end_addr, o_down_tile_base_addr,
    input  o_tile_m_idx, o_tile_n_idx, o_busy, o_done, o_err
  );

  modport slave (
    input  i_start, i_abort, i_cfg_k, i_cfg_num_m_tiles, i_cfg_num_n_tiles,
    input  i_cfg_top_base, i_cfg_left_base, i_cfg_down_base, i_sa_valid_down,
    output o_ctrl_state, o_top_sram_rd_start_addr, o_top_sram_rd_end_addr,
    output o_left_sram_rd_start_addr, o_left_sram_rd_end_addr, o_down_tile_base_addr,
    output o_tile_m_idx, o_tile_n_idx, o_busy, o_done, o_err
  );

endinterface

// File: rtl/gemm_tile_sequencer.sv
// Tile loop FSM for the output-stationary systolic array: walks M x N output tiles (n inner).
// Optional drain watchdog enabled by defining GEMM_SEQ_DRAIN_TIMEOUT_EN.
module gemm_tile_sequencer #(
  parameter int unsigned NUM_ROW              = 8,
  parameter int unsigned NUM_COL              = 8,
  parameter int unsigned LOG2_SRAM_BANK_DEPTH = 10,
  parameter int unsigned CNT_WIDTH            = 16,
  parameter int unsigned CTRL_WIDTH           = 4,
  parameter int unsigned DRAIN_TIMEOUT        = 1024
) (
  input logic                 clk,
  input logic                 rst_n,
  gemm_tile_sequencer_if.slave bus
);

  localparam int unsigned AW = LOG2_SRAM_BANK_DEPTH;
  localparam int unsigned CW = CNT_WIDTH;
  // Extra headroom so K + skew never overflows the phase counter.
  localparam int unsigned SW = CNT_WIDTH + 2;
  localparam logic [SW-1:0] SkewLast  = SW'(NUM_ROW + NUM_COL - 2);
  localparam logic [SW-1:0] FlushLast = SW'(NUM_COL - 1);
  localparam logic [SW-1:0] DrainLast = SW'(NUM_ROW - 1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSteady = 2'd1,
    StFlush  = 2'd2,
    StDrain  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  k_q, k_d, m_tiles_q, m_tiles_d, n_tiles_q, n_tiles_d;
  logic [AW-1:0]  top_base_q, top_base_d, left_base_q, left_base_d, down_base_q, down_base_d;
  logic [CW-1:0]  m_idx_q, m_idx_d, n_idx_q, n_idx_d;
  logic [SW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]  top_start_q, top_start_d, top_end_q, top_end_d;
  logic [AW-1:0]  left_start_q, left_start_d, left_end_q, left_end_d;
  logic [AW-1:0]  down_q, down_d;
  logic [AW-1:0]  tile_lin;
  logic           busy_q, busy_d, done_q, done_d;
  logic           load_addr, beat, start_acc, abort_acc, tile_done, timeout;

  function automatic logic [AW-1:0] mul_trunc(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic [2*CW-1:0] p;
    p = a * b;
    return p[AW-1:0];
  endfunction

  assign beat      = |bus.i_sa_valid_down;
  assign start_acc = (state_q == StIdle) && !busy_q && bus.i_start && !bus.i_abort;
  assign abort_acc = busy_q && bus.i_abort;
  assign tile_done = (state_q == StDrain) && beat && (cnt_q == DrainLast);

`ifdef GEMM_SEQ_DRAIN_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(DRAIN_TIMEOUT + 1);
  logic [WdW-1:0] wd_q;
  logic           err_q;

  assign timeout = (state_q == StDrain) && !tile_done && (wd_q == WdW'(DRAIN_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q <= (state_q == StDrain && !abort_acc && !timeout) ? wd_q + WdW'(1) : '0;
      if (start_acc) begin
        err_q <= 1'b0;
      end else if (timeout && !abort_acc) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.o_err = err_q;
`else
  assign timeout   = 1'b0;
  assign bus.o_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    m_tiles_d   = m_tiles_q;
    n_tiles_d   = n_tiles_q;
    top_base_d  = top_base_q;
    left_base_d = left_base_q;
    down_base_d = down_base_q;
    m_idx_d     = m_idx_q;
    n_idx_d     = n_idx_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    load_addr   = 1'b0;
    if (abort_acc || timeout) begin
      state_d   = StIdle;
      busy_d    = 1'b0;
      done_d    = timeout && !abort_acc;
      cnt_d     = '0;
      m_idx_d   = '0;
      n_idx_d   = '0;
      load_addr = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_acc) begin
            k_d         = bus.i_cfg_k;
            m_tiles_d   = bus.i_cfg_num_m_tiles;
            n_tiles_d   = bus.i_cfg_num_n_tiles;
            top_base_d  = bus.i_cfg_top_base;
            left_base_d = bus.i_cfg_left_base;
            down_base_d = bus.i_cfg_down_base;
            m_idx_d     = '0;
            n_idx_d     = '0;
            cnt_d       = '0;
            busy_d      = 1'b1;
            load_addr   = 1'b1;
            done_d      = (bus.i_cfg_k == '0) || (bus.i_cfg_num_m_tiles == '0) ||
                          (bus.i_cfg_num_n_tiles == '0);
          end else if (busy_q) begin
            // A degenerate job is busy only for its done cycle.
            if (done_q) begin
              busy_d = 1'b0;
            end else begin
              state_d = StSteady;
              cnt_d   = '0;
            end
          end
        end
        StSteady: begin
          if (cnt_q == SW'(k_q) + SkewLast) begin
            state_d = StFlush;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + SW'(1);
          end
        end
        StFlush: begin
          if (cnt_q == FlushLast) begin
            state_d = StDrain;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + SW'(1);
          end
        end
        StDrain: begin
          if (tile_done) begin
            state_d = StIdle;
            cnt_d   = '0;
            if (n_idx_q == n_tiles_q - CW'(1)) begin
              if (m_idx_q == m_tiles_q - CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
              end else begin
                n_idx_d   = '0;
                m_idx_d   = m_idx_q + CW'(1);
                load_addr = 1'b1;
              end
            end else begin
              n_idx_d   = n_idx_q + CW'(1);
              load_addr = 1'b1;
            end
          end else if (beat) begin
            cnt_d = cnt_q + SW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Next-tile addresses are formed from the next-state indices so they are valid in the IDLE gap.
  always_comb begin
    top_start_d  = top_start_q;
    top_end_d    = top_end_q;
    left_start_d = left_start_q;
    left_end_d   = left_end_q;
    down_d       = down_q;
    tile_lin     = mul_trunc(m_idx_d, n_tiles_d) + AW'(n_idx_d);
    if (load_addr) begin
      top_start_d  = top_base_d + mul_trunc(n_idx_d, k_d);
      top_end_d    = top_start_d + AW'(k_d);
      left_start_d = left_base_d + mul_trunc(m_idx_d, k_d);
      left_end_d   = left_start_d + AW'(k_d);
      down_d       = down_base_d + tile_lin * AW'(NUM_ROW);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      k_q          <= '0;
      m_tiles_q    <= '0;
      n_tiles_q    <= '0;
      top_base_q   <= '0;
      left_base_q  <= '0;
      down_base_q  <= '0;
      m_idx_q      <= '0;
      n_idx_q      <= '0;
      cnt_q        <= '0;
      top_start_q  <= '0;
      top_end_q    <= '0;
      left_start_q <= '0;
      left_end_q   <= '0;
      down_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      m_tiles_q    <= m_tiles_d;
      n_tiles_q    <= n_tiles_d;
      top_base_q   <= top_base_d;
      left_base_q  <= left_base_d;
      down_base_q  <= down_base_d;
      m_idx_q      <= m_idx_d;
      n_idx_q      <= n_idx_d;
      cnt_q        <= cnt_d;
      top_start_q  <= top_start_d;
      top_end_q    <= top_end_d;
      left_start_q <= left_start_d;
      left_end_q   <= left_end_d;
      down_q       <= down_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.o_ctrl_state              = CTRL_WIDTH'(state_q);
  assign bus.o_top_sram_rd_start_addr  = top_start_q;
  assign bus.o_top_sram_rd_end_addr    = top_end_q;
  assign bus.o_left_sram_rd_start_addr = left_start_q;
  assign bus.o_left_sram_rd_end_addr   = left_end_q;
  assign bus.o_down_tile_base_addr     = down_q;
  assign bus.o_tile_m_idx              = m_idx_q;
  assign bus.o_tile_n_idx              = n_idx_q;
  assign bus.o_busy                    = busy_q;
  assign bus.o_done                    = done_q;

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Directed bench for gemm_tile_sequencer: per-tile address expectations are queued at job
// start and popped as each tile enters STEADY; phase lengths and done/busy are checked inline.
module tb_gemm_tile_sequencer;

  localparam int unsigned AW = 10;
  localparam int unsigned CW = 16;
  localparam int unsigned NR = 8;
  localparam int unsigned NC = 8;
  localparam int ADDR_MOD = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gemm_tile_sequencer_if #(
    .NUM_COL(NC), .LOG2_SRAM_BANK_DEPTH(AW), .CNT_WIDTH(CW), .CTRL_WIDTH(4)
  ) bus ();

  gemm_tile_sequencer #(
    .NUM_ROW(NR), .NUM_COL(NC), .LOG2_SRAM_BANK_DEPTH(AW), .CNT_WIDTH(CW),
    .CTRL_WIDTH(4), .DRAIN_TIMEOUT(1024)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    int m; int n; int ts; int te; int ls; int le; int db;
  } tile_t;

  tile_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_job(input int k, input int mt, input int nt,
                          input int tb, input int lb, input int db);
    tile_t t;
    for (int mi = 0; mi < mt; mi++) begin
      for (int ni = 0; ni < nt; ni++) begin
        t.m  = mi;
        t.n  = ni;
        t.ts = (tb + ni * k) % ADDR_MOD;
        t.te = (t.ts + k) % ADDR_MOD;
        t.ls = (lb + mi * k) % ADDR_MOD;
        t.le = (t.ls + k) % ADDR_MOD;
        t.db = (db + (mi * nt + ni) * int'(NR)) % ADDR_MOD;
        sb.push_back(t);
      end
    end
  endtask

  task automatic start_job(input int k, input int mt, input int nt,
                           input int tb, input int lb, input int db);
    bus.i_cfg_k           = CW'(k);
    bus.i_cfg_num_m_tiles = CW'(mt);
    bus.i_cfg_num_n_tiles = CW'(nt);
    bus.i_cfg_top_base    = AW'(tb);
    bus.i_cfg_left_base   = AW'(lb);
    bus.i_cfg_down_base   = AW'(db);
    bus.i_start           = 1'b1;
    step();
    bus.i_start           = 1'b0;
  endtask

  task automatic check_tile(input string ph, input tile_t t);
    chk({ph, "_top_start"}, bus.o_top_sram_rd_start_addr, t.ts);
    chk({ph, "_top_end"}, bus.o_top_sram_rd_end_addr, t.te);
    chk({ph, "_left_start"}, bus.o_left_sram_rd_start_addr, t.ls);
    chk({ph, "_left_end"}, bus.o_left_sram_rd_end_addr, t.le);
    chk({ph, "_down_base"}, bus.o_down_tile_base_addr, t.db);
    chk({ph, "_m_idx"}, bus.o_tile_m_idx, t.m);
    chk({ph, "_n_idx"}, bus.o_tile_n_idx, t.n);
  endtask

  // Follows a running job to its done pulse; optionally pokes a start while busy.
  task automatic watch_job(input int k, input bit poke_start);
    int prev, cur, run, dones;
    tile_t t;
    prev  = 0;
    run   = 0;
    dones = 0;
    t     = '{default: 0};
    chk("start_busy", bus.o_busy, 1);
    for (int cyc = 0; cyc < 20000; cyc++) begin
      cur = int'(bus.o_ctrl_state);
      if (poke_start) begin
        bus.i_start        = (cyc == 5);
        bus.i_cfg_top_base = (cyc == 5) ? AW'(777) : bus.i_cfg_top_base;
        bus.i_cfg_k        = (cyc == 5) ? CW'(0) : bus.i_cfg_k;
      end
      if (cur != prev) begin
        if (prev == 1) chk("steady_len", run, k + int'(NR + NC) - 1);
        if (prev == 2) chk("flush_len", run, NC);
        if (prev == 3) chk("drain_len", run, NR);
        if (prev == 0 && cur == 1) chk("idle_gap", run, 1);
        if (cur == 1) begin
          chk("sb_nonempty", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            t = sb.pop_front();
            check_tile("steady", t);
          end
          chk("busy_run", bus.o_busy, 1);
        end
        if (cur == 3) check_tile("drain", t);
        run = 1;
      end else begin
        run++;
      end
      if (bus.o_done === 1'b1) begin
        chk("done_busy", bus.o_busy, 0);
        chk("done_state", cur, 0);
        dones++;
        break;
      end
      prev = cur;
      step();
    end
    chk("done_seen", dones, 1);
    chk("sb_drained", sb.size(), 0);
    sb.delete();
    step();
    chk("done_one_cycle", bus.o_done, 0);
    chk("idle_after_done", bus.o_busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    int found;
    int seen;
    bus.i_start           = 1'b0;
    bus.i_abort           = 1'b0;
    bus.i_cfg_k           = '0;
    bus.i_cfg_num_m_tiles = '0;
    bus.i_cfg_num_n_tiles = '0;
    bus.i_cfg_top_base    = '0;
    bus.i_cfg_left_base   = '0;
    bus.i_cfg_down_base   = '0;
    bus.i_sa_valid_down   = '0;

    // Reset values.
    #12;
    chk("rst_state", bus.o_ctrl_state, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_done", bus.o_done, 0);
    chk("rst_err", bus.o_err, 0);
    chk("rst_addr", {bus.o_top_sram_rd_start_addr, bus.o_left_sram_rd_end_addr,
                     bus.o_down_tile_base_addr}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single tile; valid held high everywhere, so beats outside DRAIN must be ignored.
    bus.i_sa_valid_down = 8'h80;
    push_job(4, 1, 1, 0, 16, 32);
    start_job(4, 1, 1, 0, 16, 32);
    watch_job(4, 1'b0);

    // 2x2 tiles with a start pulse dropped while busy.
    push_job(4, 2, 2, 0, 16, 32);
    start_job(4, 2, 2, 0, 16, 32);
    watch_job(4, 1'b1);

    // Address wrap-around modulo the SRAM depth.
    push_job(300, 2, 3, 900, 1000, 1020);
    start_job(300, 2, 3, 900, 1000, 1020);
    watch_job(300, 1'b0);

    // Degenerate K=0, with a start during its busy cycle.
    start_job(0, 1, 1, 0, 16, 32);
    chk("degen_done", bus.o_done, 1);
    chk("degen_busy", bus.o_busy, 1);
    chk("degen_state", bus.o_ctrl_state, 0);
    bus.i_cfg_k = CW'(4);
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    chk("degen_done_clr", bus.o_done, 0);
    chk("degen_busy_clr", bus.o_busy, 0);
    step();
    chk("degen_drop_start", {bus.o_busy, bus.o_ctrl_state}, 0);

    // Degenerate M=0.
    start_job(4, 0, 3, 0, 16, 32);
    chk("degen_m0_done", bus.o_done, 1);
    step();
    chk("degen_m0_state", {bus.o_busy, bus.o_ctrl_state}, 0);

    // Abort and start together while idle: start dropped.
    bus.i_abort = 1'b1;
    start_job(4, 1, 1, 0, 16, 32);
    bus.i_abort = 1'b0;
    chk("abort_start_busy", bus.o_busy, 0);
    step();
    chk("abort_start_state", bus.o_ctrl_state, 0);

    // Abort during DRAIN of tile 0.
    start_job(4, 2, 2, 0, 16, 32);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.o_ctrl_state == 4'd3) begin
        found = 1;
        break;
      end
      step();
    end
    chk("reach_drain", found, 1);
    bus.i_abort = 1'b1;
    step();
    bus.i_abort = 1'b0;
    chk("abort_state", bus.o_ctrl_state, 0);
    chk("abort_busy", bus.o_busy, 0);
    chk("abort_done", bus.o_done, 0);
    chk("abort_idx", {bus.o_tile_m_idx, bus.o_tile_n_idx}, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.o_done === 1'b1 || bus.o_ctrl_state != 4'd0) seen++;
      step();
    end
    chk("abort_quiet", seen, 0);

    // Reset in STEADY of tile (1,0), then a full job.
    start_job(4, 2, 2, 0, 16, 32);
    found = 0;
    for (int i = 0; i < 500; i++) begin
      if (bus.o_ctrl_state == 4'd1 && bus.o_tile_m_idx == CW'(1)) begin
        found = 1;
        break;
      end
      step();
    end
    chk("reach_m1_steady", found, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", bus.o_ctrl_state, 0);
    chk("mid_rst_flags", {bus.o_busy, bus.o_done, bus.o_err}, 0);
    chk("mid_rst_addr", {bus.o_top_sram_rd_start_addr, bus.o_top_sram_rd_end_addr,
                         bus.o_left_sram_rd_start_addr, bus.o_left_sram_rd_end_addr,
                         bus.o_down_tile_base_addr}, 0);
    chk("mid_rst_idx", {bus.o_tile_m_idx, bus.o_tile_n_idx}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    push_job(4, 2, 2, 0, 16, 32);
    start_job(4, 2, 2, 0, 16, 32);
    watch_job(4, 1'b0);

`ifdef GEMM_SEQ_DRAIN_TIMEOUT_EN
    // No valid beats: watchdog fires after 1024 DRAIN cycles.
    bus.i_sa_valid_down = '0;
    start_job(4, 1, 1, 0, 16, 32);
    found = 0;
    seen  = 0;
    for (int i = 0; i < 1500; i++) begin
      if (bus.o_ctrl_state == 4'd3) seen++;
      if (bus.o_done === 1'b1) begin
        found = 1;
        break;
      end
      step();
    end
    chk("wd_done", found, 1);
    chk("wd_drain_cycles", seen, 1024);
    chk("wd_err", bus.o_err, 1);
    chk("wd_busy", bus.o_busy, 0);
    step();
    chk("wd_err_sticky", bus.o_err, 1);
    start_job(0, 1, 1, 0, 16, 32);
    chk("wd_err_cleared", bus.o_err, 0);
    step();
`else
    chk("err_tied_low", bus.o_err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
